// File: rtl/dircc_output_arbiter_pkg.sv
// Shared types and constants for the dircc per-direction output arbiter.
package dircc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_EMPTY_W = 2;

  // Requester index assignment on each output direction.
  localparam int NORTH = 0;
  localparam int SOUTH = 1;
  localparam int EAST  = 2;
  localparam int WEST  = 3;
  localparam int LOCAL = 4;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dircc_output_arbiter_if.sv
// Avalon-ST bundle between NUM_IN requesters, the arbiter and its single source.
interface dircc_output_arbiter_if
  import dircc_arb_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int EMPTY_W = DEF_EMPTY_W
);

  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN-1:0]         in_startofpacket;
  logic [NUM_IN-1:0]         in_endofpacket;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [EMPTY_W-1:0]        out_empty;
  logic [NUM_IN-1:0]         grant;
  logic                      proto_err;

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
           grant, proto_err
  );

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
           grant, proto_err
  );

endinterface

// File: rtl/dircc_output_arbiter_rr_picker.sv
// Combinational rotate-priority selector: first set request at or after i_rr_ptr, with wrap.
module dircc_rr_picker #(
  parameter int NUM_IN = 5
) (
  input  logic [NUM_IN-1:0]         i_req,
  input  logic [$clog2(NUM_IN)-1:0] i_rr_ptr,
  output logic [NUM_IN-1:0]         o_grant,
  output logic [$clog2(NUM_IN)-1:0] o_idx,
  output logic                      o_any
);

  localparam int IDX_W = $clog2(NUM_IN);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      // i_rr_ptr < NUM_IN, so one conditional subtract is enough for the wrap.
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_IN)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_IN);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/dircc_output_arbiter.sv
// Packet-granular round-robin arbiter for one dircc node output direction.
// Optional protocol checker enabled by macro DIRCC_ARB_PROTOCOL_CHECK_EN.
module dircc_output_arbiter
  import dircc_arb_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int EMPTY_W = DEF_EMPTY_W
) (
  input  logic                   clk_routing_clk,
  input  logic                   reset_routing_reset_n,
  dircc_output_arbiter_if.slave  io_arb
);

  localparam int IDX_W = $clog2(NUM_IN);

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_IN-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;

  logic [NUM_IN-1:0]   w_pick_grant;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;

  logic                w_g_valid;
  logic                w_g_sop;
  logic                w_g_eop;
  logic [DATA_W-1:0]   w_g_data;
  logic [EMPTY_W-1:0]  w_g_empty;

  logic                w_out_free;
  logic                w_xfer;

  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [EMPTY_W-1:0]  r_out_empty;

  dircc_rr_picker #(
    .NUM_IN (NUM_IN)
  ) u_picker (
    .i_req    (io_arb.in_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_grant),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_g_valid = 1'b0;
    w_g_sop   = 1'b0;
    w_g_eop   = 1'b0;
    w_g_data  = '0;
    w_g_empty = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (r_gidx == IDX_W'(k)) begin
        w_g_valid = io_arb.in_valid[k];
        w_g_sop   = io_arb.in_startofpacket[k];
        w_g_eop   = io_arb.in_endofpacket[k];
        w_g_data  = io_arb.in_data[k*DATA_W +: DATA_W];
        w_g_empty = io_arb.in_empty[k*EMPTY_W +: EMPTY_W];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign w_out_free = !r_out_valid || io_arb.out_ready;
  assign w_xfer     = (r_state == LOCKED) && w_g_valid && w_out_free;

  assign io_arb.in_ready = ((r_state == LOCKED) && w_out_free) ? r_grant : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_gidx_nxt   = r_gidx;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_pick_grant;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      LOCKED: begin
        // Grant is held until the EOP beat is accepted; no timeout.
        if (w_xfer && w_g_eop) begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = IDX_W'(rr_next(int'(r_gidx), NUM_IN));
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_g_data;
      r_out_sop   <= w_g_sop;
      r_out_eop   <= w_g_eop;
      r_out_empty <= w_g_empty;
    end else if (io_arb.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_arb.out_valid         = r_out_valid;
  assign io_arb.out_data          = r_out_data;
  assign io_arb.out_startofpacket = r_out_sop;
  assign io_arb.out_endofpacket   = r_out_eop;
  assign io_arb.out_empty         = r_out_empty;
  assign io_arb.grant             = r_grant;

`ifdef DIRCC_ARB_PROTOCOL_CHECK_EN
  logic r_first_beat;
  logic r_proto_err;

  // A beat is malformed when SOP disagrees with being the first beat of the grant.
  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      r_first_beat <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_pick_any) begin
        r_first_beat <= 1'b1;
      end else if (w_xfer) begin
        r_first_beat <= 1'b0;
      end
      if (w_xfer && (r_first_beat ^ w_g_sop)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign io_arb.proto_err = r_proto_err;
`else
  assign io_arb.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dircc_output_arbiter.sv
// Directed table-driven bench for dircc_output_arbiter plus multi-cycle corner sequences.
module tb_dircc_output_arbiter;
  import dircc_arb_pkg::*;

  localparam int NUM_IN  = 5;
  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

`ifdef DIRCC_ARB_PROTOCOL_CHECK_EN
  localparam logic PE_EXP = 1'b1;
`else
  localparam logic PE_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dircc_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) arb ();

  dircc_output_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk_routing_clk       (clk),
    .reset_routing_reset_n (rst_n),
    .io_arb                (arb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  valid;
    logic [4:0]  sop;
    logic [4:0]  eop;
    logic [7:0]  dat;
    logic [1:0]  empty;
    logic        ordy;
    logic [4:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic        exp_sop;
    logic        exp_eop;
    logic [1:0]  exp_empty;
    logic [4:0]  exp_grant;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int r, input logic [7:0] b);
    return {8'(r), 16'h0000, b};
  endfunction

  task automatic drive(input logic [4:0] v, input logic [4:0] s, input logic [4:0] e,
                       input logic [7:0] d, input logic [1:0] emp, input logic ordy);
    logic [NUM_IN*DATA_W-1:0]  dv;
    logic [NUM_IN*EMPTY_W-1:0] ev;
    for (int i = 0; i < NUM_IN; i++) begin
      dv[i*DATA_W +: DATA_W]   = mkdata(i, d);
      ev[i*EMPTY_W +: EMPTY_W] = emp;
    end
    arb.in_data          = dv;
    arb.in_empty         = ev;
    arb.in_valid         = v;
    arb.in_startofpacket = s;
    arb.in_endofpacket   = e;
    arb.out_ready        = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_q[$];
    int cyc_q[$];
    logic [31:0] got_q[$];
    logic [31:0] prev;
    int b0;
    logic r1_done;
    logic x0, x1, hold;
    int early;
    logic [4:0] v, s, e;

    //         valid     sop       eop       dat    emp  ordy exp_rdy   ov    exp_data          sop   eop   emp   grant
    tbl[0] = '{5'b00100, 5'b00100, 5'b00000, 8'hA0, 2'd0, 1'b1, 5'b00000, 1'b0, 32'h0,            1'b0, 1'b0, 2'd0, 5'b00100};
    tbl[1] = '{5'b00100, 5'b00100, 5'b00000, 8'hA0, 2'd0, 1'b1, 5'b00100, 1'b1, 32'h020000A0,     1'b1, 1'b0, 2'd0, 5'b00100};
    tbl[2] = '{5'b00100, 5'b00000, 5'b00000, 8'hA1, 2'd0, 1'b1, 5'b00100, 1'b1, 32'h020000A1,     1'b0, 1'b0, 2'd0, 5'b00100};
    tbl[3] = '{5'b00100, 5'b00000, 5'b00100, 8'hA2, 2'd2, 1'b1, 5'b00100, 1'b1, 32'h020000A2,     1'b0, 1'b1, 2'd2, 5'b00000};
    tbl[4] = '{5'b00000, 5'b00000, 5'b00000, 8'h00, 2'd0, 1'b1, 5'b00000, 1'b0, 32'h0,            1'b0, 1'b0, 2'd0, 5'b00000};
    tbl[5] = '{5'b10010, 5'b10010, 5'b10010, 8'h11, 2'd0, 1'b1, 5'b00000, 1'b0, 32'h0,            1'b0, 1'b0, 2'd0, 5'b10000};
    tbl[6] = '{5'b10010, 5'b10010, 5'b10010, 8'h11, 2'd0, 1'b1, 5'b10000, 1'b1, 32'h04000011,     1'b1, 1'b1, 2'd0, 5'b00000};
    tbl[7] = '{5'b00010, 5'b00010, 5'b00010, 8'h11, 2'd0, 1'b1, 5'b00000, 1'b0, 32'h0,            1'b0, 1'b0, 2'd0, 5'b00010};
    tbl[8] = '{5'b00010, 5'b00010, 5'b00010, 8'h11, 2'd0, 1'b1, 5'b00010, 1'b1, 32'h01000011,     1'b1, 1'b1, 2'd0, 5'b00000};
    tbl[9] = '{5'b00000, 5'b00000, 5'b00000, 8'h00, 2'd0, 1'b1, 5'b00000, 1'b0, 32'h0,            1'b0, 1'b0, 2'd0, 5'b00000};

    // Reset values, then an idle stretch
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    tick();
    tick();
    chk("rst_out_valid", arb.out_valid, 0);
    chk("rst_out_data", arb.out_data, 0);
    chk("rst_out_sop", arb.out_startofpacket, 0);
    chk("rst_out_eop", arb.out_endofpacket, 0);
    chk("rst_out_empty", arb.out_empty, 0);
    chk("rst_grant", arb.grant, 0);
    chk("rst_in_ready", arb.in_ready, 0);
    chk("rst_proto_err", arb.proto_err, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle%0d_out_valid", c), arb.out_valid, 0);
    end

    // Table: requester 2 three-beat packet, then rr_ptr=3 selects 4 over 1
    for (int t = 0; t < 10; t++) begin
      drive(tbl[t].valid, tbl[t].sop, tbl[t].eop, tbl[t].dat, tbl[t].empty, tbl[t].ordy);
      #1;
      chk($sformatf("t%0d_in_ready", t), arb.in_ready, tbl[t].exp_rdy);
      tick();
      chk($sformatf("t%0d_out_valid", t), arb.out_valid, tbl[t].exp_ov);
      if (tbl[t].exp_ov) begin
        chk($sformatf("t%0d_out_data", t), arb.out_data, tbl[t].exp_data);
        chk($sformatf("t%0d_out_sop", t), arb.out_startofpacket, tbl[t].exp_sop);
        chk($sformatf("t%0d_out_eop", t), arb.out_endofpacket, tbl[t].exp_eop);
        chk($sformatf("t%0d_out_empty", t), arb.out_empty, tbl[t].exp_empty);
      end
      chk($sformatf("t%0d_grant", t), arb.grant, tbl[t].exp_grant);
    end
    chk("tbl_proto_err", arb.proto_err, 0);

    // Fairness: all requesters continuously offer single-beat packets
    do_reset();
    drive(5'b11111, 5'b11111, 5'b11111, 8'h55, 2'd0, 1'b1);
    for (int c = 0; c < 40 && idx_q.size() < 6; c++) begin
      tick();
      if (arb.out_valid) begin
        idx_q.push_back(int'(arb.out_data[31:24]));
        cyc_q.push_back(c);
      end
    end
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    chk("rr_beats", idx_q.size(), 6);
    for (int k = 0; k < idx_q.size(); k++) begin
      chk($sformatf("rr_src%0d", k), idx_q[k], k % NUM_IN);
      if (k > 0) chk($sformatf("rr_gap%0d", k), cyc_q[k] - cyc_q[k-1], 2);
    end
    tick();

    // Backpressure: requester 0 three beats with out_ready 1,0,0,1 mid-packet; requester 1 waits
    do_reset();
    b0 = 0;
    r1_done = 1'b0;
    early = 0;
    for (int c = 0; c < 16; c++) begin
      v = {3'b000, !r1_done, (b0 < 3)};
      s = {3'b000, 1'b1, (b0 == 0)};
      e = {3'b000, 1'b1, (b0 == 2)};
      drive(v, s, e, 8'hB0 + 8'(b0), 2'd0, !(c == 3 || c == 4));
      #1;
      x0   = arb.in_valid[0] && arb.in_ready[0];
      x1   = arb.in_valid[1] && arb.in_ready[1];
      hold = arb.out_valid && !arb.out_ready;
      prev = arb.out_data;
      if (arb.out_valid && arb.out_ready) got_q.push_back(arb.out_data);
      if (b0 < 3 && (arb.grant[1] || arb.in_ready[1])) early++;
      tick();
      if (x0) b0++;
      if (x1) r1_done = 1'b1;
      if (hold) begin
        chk($sformatf("bp_hold_valid_c%0d", c), arb.out_valid, 1);
        chk($sformatf("bp_hold_data_c%0d", c), arb.out_data, prev);
      end
    end
    chk("bp_req1_early", early, 0);
    chk("bp_beats", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("bp_beat0", got_q[0], 32'h000000B0);
      chk("bp_beat1", got_q[1], 32'h000000B1);
      chk("bp_beat2", got_q[2], 32'h000000B2);
      chk("bp_beat3", got_q[3], 32'h010000B3);
    end

    // Reset pulsed after beat 2 of a 4-beat packet from requester 2
    do_reset();
    drive(5'b00100, 5'b00100, 5'b00000, 8'hC0, 2'd0, 1'b1);
    tick();
    tick();
    drive(5'b00100, 5'b00000, 5'b00000, 8'hC1, 2'd0, 1'b1);
    tick();
    chk("mr_beat2_data", arb.out_data, 32'h020000C1);
    chk("mr_beat2_grant", arb.grant, 5'b00100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_out_valid", arb.out_valid, 0);
    chk("mr_rst_grant", arb.grant, 0);
    chk("mr_rst_in_ready", arb.in_ready, 0);
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(5'b01000, 5'b01000, 5'b01000, 8'hD3, 2'd1, 1'b1);
    tick();
    chk("mr_new_grant", arb.grant, 5'b01000);
    chk("mr_new_no_valid", arb.out_valid, 0);
    tick();
    chk("mr_new_valid", arb.out_valid, 1);
    chk("mr_new_data", arb.out_data, 32'h030000D3);
    chk("mr_new_empty", arb.out_empty, 2'd1);
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    tick();

    // First beat of a grant arriving without SOP
    do_reset();
    drive(5'b00010, 5'b00000, 5'b00010, 8'hE1, 2'd0, 1'b1);
    tick();
    chk("pe_before", arb.proto_err, 0);
    tick();
    chk("pe_fwd_data", arb.out_data, 32'h010000E1);
    chk("pe_fwd_sop", arb.out_startofpacket, 0);
    chk("pe_set", arb.proto_err, PE_EXP);
    drive(5'b0, 5'b0, 5'b0, 8'h00, 2'd0, 1'b1);
    tick();
    tick();
    chk("pe_sticky", arb.proto_err, PE_EXP);
    do_reset();
    chk("pe_cleared", arb.proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
